// File: rtl/mem_access_stage_if.sv
// ============================================================================
// Module   : mem_access_stage_if
// Brief    : Data-memory request/acknowledge bus used by the MEM stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_stage_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        output mem_ack_i
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module   : mem_access_stage
// Brief    : Pipeline MEM stage with bus handshake, wait-state timeout,
//            alignment check and the MEM/WB pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_i,
    input  wire logic [31:0]       ALUresult_i,
    input  wire logic [31:0]       WriteData_i,
    input  wire logic [4:0]        InstDst_i,
    input  wire logic              MemToReg_i,
    input  wire logic              RegWrite_i,
    input  wire logic              MemWrite_i,
    input  wire logic              MemRead_i,
    mem_access_stage_if.master     bus,
    output logic                   stall_o,
    output logic [31:0]            ReadData_o,
    output logic [31:0]            ALUresult_o,
    output logic [4:0]             InstDst_o,
    output logic                   MemToReg_o,
    output logic                   RegWrite_o,
    output logic                   bus_err_o
);

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;

    logic w_access;
    logic w_aligned;
    logic w_active;
    logic w_timeout;

    always_comb begin
        w_access  = MemRead_i | MemWrite_i;
        w_aligned = (ALUresult_i[1:0] == 2'b00);
        // EX/MEM is frozen while in WAIT, so the held inputs still describe the access
        w_active  = (r_state == S_WAIT) || (w_access && w_aligned);
        w_timeout = (r_state == S_WAIT) && (r_cnt == C_CNT_LAST) && !bus.mem_ack_i;
    end

    always_comb begin
        bus.mem_req_o   = w_active && !rst_i;
        bus.mem_we_o    = MemWrite_i && !rst_i;
        bus.mem_addr_o  = rst_i ? 32'd0 : ALUresult_i;
        bus.mem_wdata_o = rst_i ? 32'd0 : WriteData_i;
        stall_o         = w_active && !bus.mem_ack_i && !w_timeout && !rst_i;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            ReadData_o  <= 32'd0;
            ALUresult_o <= 32'd0;
            InstDst_o   <= 5'd0;
            MemToReg_o  <= 1'b0;
            RegWrite_o  <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            // Default: bubble into WB; overridden below on pass-through or completion
            ReadData_o  <= 32'd0;
            ALUresult_o <= 32'd0;
            InstDst_o   <= 5'd0;
            MemToReg_o  <= 1'b0;
            RegWrite_o  <= 1'b0;
            if (w_active && bus.mem_ack_i) begin
                ReadData_o  <= MemWrite_i ? 32'd0 : bus.mem_rdata_i;
                ALUresult_o <= ALUresult_i;
                InstDst_o   <= InstDst_i;
                MemToReg_o  <= MemToReg_i;
                RegWrite_o  <= RegWrite_i;
                r_state     <= S_IDLE;
                r_cnt       <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_access && !w_aligned) begin
                            bus_err_o <= 1'b1;
                        end else if (w_access) begin
                            r_state <= S_WAIT;
                            r_cnt   <= 8'd0;
                        end else begin
                            ALUresult_o <= ALUresult_i;
                            InstDst_o   <= InstDst_i;
                            MemToReg_o  <= MemToReg_i;
                            RegWrite_o  <= RegWrite_i;
                        end
                    end
                    S_WAIT: begin
                        if (w_timeout) begin
                            bus_err_o <= 1'b1;
                            r_state   <= S_IDLE;
                            r_cnt     <= 8'd0;
                        end else if (r_cnt != C_CNT_LAST) begin
                            r_cnt <= 8'(r_cnt + 8'd1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire
